// File: rtl/pcie_dll_tx.sv
// PCIe Data Link Layer transmit path: sequence numbering, LCRC generation,
// retry buffer with Ack/Nak handling and timer/Nak-driven replay.
module pcie_dll_tx #(
    parameter int TLP_W          = 256,
    parameter int RB_DEPTH       = 8,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tlp_valid_i,
    input  logic [TLP_W-1:0]             tlp_i,
    output logic                         tlp_ready_o,
    output logic                         phy_valid_o,
    output logic [TLP_W+47:0]            phy_tlp_o,
    input  logic                         phy_ready_i,
    input  logic                         dllp_valid_i,
    input  logic [7:0]                   dllp_type_i,
    input  logic [11:0]                  dllp_seq_i,
    output logic                         replay_active_o,
    output logic                         link_retrain_o,
    output logic                         dllp_err_o,
    output logic [$clog2(RB_DEPTH):0]    rb_count_o
);
    localparam int PW = $clog2(RB_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = TLP_W + 48;
    localparam int DW = TLP_W + 16;
    localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    // MSB-first CRC-32 (poly 04C11DB7, all-ones preset, inverted result), matching the RX checker
    function automatic logic [31:0] crc32(input logic [DW-1:0] data);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = DW - 1; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return ~c;
    endfunction

    logic [FW-1:0]     rb_mem_r [RB_DEPTH];
    logic [0:0]        state_r, state_s;
    logic [PW-1:0]     head_r;
    logic [CW-1:0]     count_r, rp_off_r, rp_off_s;
    logic [11:0]       next_seq_r, acked_seq_r;
    logic [TW-1:0]     timer_r;
    logic [1:0]        replay_num_r;
    logic              phy_valid_r, link_retrain_r, dllp_err_r;
    logic [FW-1:0]     phy_tlp_r;

    logic              loadable_s, tlp_ready_s, accept_s;
    logic              is_ack_s, is_nak_s, in_win_s, ok_s, err_s, ack_prog_s;
    logic              timeout_s, trig_s, replay_load_s;
    logic [11:0]       dist_s;
    logic [CW-1:0]     purge_s, left_s, rp_adj_s;
    logic [PW-1:0]     rd_idx_s, wr_idx_s;
    logic [DW-1:0]     hdr_s;
    logic [FW-1:0]     new_frame_s, load_frame_s;

    assign loadable_s  = !phy_valid_r || phy_ready_i;
    assign tlp_ready_s = rst_n && (state_r == ST_NORMAL) && (count_r < CW'(RB_DEPTH)) && loadable_s;
    assign accept_s    = tlp_valid_i && tlp_ready_s;

    // Window check is against the pre-update count; the distance is modulo the 12-bit sequence space
    assign dist_s     = dllp_seq_i - acked_seq_r;
    assign is_ack_s   = dllp_valid_i && (dllp_type_i == 8'h00);
    assign is_nak_s   = dllp_valid_i && (dllp_type_i == 8'h10);
    assign in_win_s   = dist_s <= 12'(count_r);
    assign ok_s       = (is_ack_s || is_nak_s) && in_win_s;
    assign err_s      = (is_ack_s || is_nak_s) && !in_win_s;
    assign purge_s    = ok_s ? dist_s[CW-1:0] : {CW{1'b0}};
    assign left_s     = count_r - purge_s;
    assign ack_prog_s = is_ack_s && ok_s && (purge_s != {CW{1'b0}});

    assign timeout_s = (state_r == ST_NORMAL) && (count_r != {CW{1'b0}}) &&
                       (timer_r == TW'(REPLAY_TIMEOUT - 1));
    assign trig_s    = (left_s != {CW{1'b0}}) &&
                       ((is_nak_s && ok_s) || (timeout_s && !ack_prog_s));

    // The replay pointer is an offset from the oldest entry, so purging shifts it down
    assign rp_adj_s      = (rp_off_r >= purge_s) ? (rp_off_r - purge_s) : {CW{1'b0}};
    assign rd_idx_s      = head_r + purge_s[PW-1:0] + rp_adj_s[PW-1:0];
    assign wr_idx_s      = head_r + count_r[PW-1:0];
    assign replay_load_s = (state_r == ST_REPLAY) && !trig_s && loadable_s && (left_s != {CW{1'b0}});

    assign hdr_s       = {4'b0000, next_seq_r, tlp_i};
    assign new_frame_s = {hdr_s, crc32(hdr_s)};

    // Frame source for the output register: fresh TLP or a buffered replay frame
    always_comb begin
        load_frame_s = phy_tlp_r;
        if (accept_s) begin
            load_frame_s = new_frame_s;
        end else if (replay_load_s) begin
            load_frame_s = rb_mem_r[rd_idx_s];
        end else begin
            load_frame_s = phy_tlp_r;
        end
    end

    // NORMAL/REPLAY sequencing and replay pointer advance
    always_comb begin
        state_s  = state_r;
        rp_off_s = rp_off_r;
        if (trig_s) begin
            state_s  = ST_REPLAY;
            rp_off_s = {CW{1'b0}};
        end else if (state_r == ST_REPLAY) begin
            if (left_s == {CW{1'b0}}) begin
                state_s  = ST_NORMAL;
                rp_off_s = {CW{1'b0}};
            end else if (replay_load_s) begin
                rp_off_s = rp_adj_s + CW'(1);
                state_s  = ((rp_adj_s + CW'(1)) >= left_s) ? ST_NORMAL : ST_REPLAY;
            end else begin
                rp_off_s = rp_adj_s;
                state_s  = ST_REPLAY;
            end
        end else begin
            state_s  = ST_NORMAL;
            rp_off_s = {CW{1'b0}};
        end
    end

    // Retry buffer storage; frames are kept whole so replays are bit-identical
    always_ff @(posedge clk) begin
        if (accept_s) begin
            rb_mem_r[wr_idx_s] <= new_frame_s;
        end
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_NORMAL;
            head_r         <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            rp_off_r       <= {CW{1'b0}};
            next_seq_r     <= 12'h000;
            acked_seq_r    <= 12'hFFF;
            timer_r        <= {TW{1'b0}};
            replay_num_r   <= 2'd0;
            phy_valid_r    <= 1'b0;
            phy_tlp_r      <= {FW{1'b0}};
            link_retrain_r <= 1'b0;
            dllp_err_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            rp_off_r       <= rp_off_s;
            head_r         <= head_r + purge_s[PW-1:0];
            count_r        <= left_s + CW'(accept_s);
            next_seq_r     <= accept_s ? (next_seq_r + 12'd1) : next_seq_r;
            acked_seq_r    <= (ok_s && (purge_s != {CW{1'b0}})) ? dllp_seq_i : acked_seq_r;
            timer_r        <= ((state_r == ST_REPLAY) || (count_r == {CW{1'b0}}) || trig_s || ack_prog_s)
                              ? {TW{1'b0}} : (timer_r + TW'(1));
            if (ack_prog_s) begin
                replay_num_r <= 2'd0;
            end else if (trig_s) begin
                replay_num_r <= (replay_num_r == 2'd3) ? 2'd0 : (replay_num_r + 2'd1);
            end else begin
                replay_num_r <= replay_num_r;
            end
            link_retrain_r <= trig_s && (replay_num_r == 2'd3);
            dllp_err_r     <= err_s;
            if (loadable_s) begin
                phy_valid_r <= accept_s || replay_load_s;
                phy_tlp_r   <= load_frame_s;
            end else begin
                phy_valid_r <= phy_valid_r;
                phy_tlp_r   <= phy_tlp_r;
            end
        end
    end

    assign tlp_ready_o     = tlp_ready_s;
    assign phy_valid_o     = phy_valid_r;
    assign phy_tlp_o       = phy_tlp_r;
    assign replay_active_o = (state_r == ST_REPLAY);
    assign link_retrain_o  = link_retrain_r;
    assign dllp_err_o      = dllp_err_r;
    assign rb_count_o      = count_r;

endmodule

// File: tb/tb_pcie_dll_tx.sv
// Self-checking bench for pcie_dll_tx: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pcie_dll_tx;
    localparam int TLP_W = 256;
    localparam int RB_DEPTH = 8;
    localparam int RT = 1024;
    localparam int FW = TLP_W + 48;
    localparam int DW = TLP_W + 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tlp_valid_i = 1'b0;
    logic [TLP_W-1:0]  tlp_i = '0;
    logic              tlp_ready_o;
    logic              phy_valid_o;
    logic [FW-1:0]     phy_tlp_o;
    logic              phy_ready_i = 1'b1;
    logic              dllp_valid_i = 1'b0;
    logic [7:0]        dllp_type_i = 8'h00;
    logic [11:0]       dllp_seq_i = 12'h000;
    logic              replay_active_o;
    logic              link_retrain_o;
    logic              dllp_err_o;
    logic [3:0]        rb_count_o;

    always #5 clk = ~clk;

    pcie_dll_tx #(.TLP_W(TLP_W), .RB_DEPTH(RB_DEPTH), .REPLAY_TIMEOUT(RT)) dut (
        .clk(clk), .rst_n(rst_n), .tlp_valid_i(tlp_valid_i), .tlp_i(tlp_i),
        .tlp_ready_o(tlp_ready_o), .phy_valid_o(phy_valid_o), .phy_tlp_o(phy_tlp_o),
        .phy_ready_i(phy_ready_i), .dllp_valid_i(dllp_valid_i), .dllp_type_i(dllp_type_i),
        .dllp_seq_i(dllp_seq_i), .replay_active_o(replay_active_o),
        .link_retrain_o(link_retrain_o), .dllp_err_o(dllp_err_o), .rb_count_o(rb_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding frames as a queue, oldest at index 0
    bit [FW-1:0] mq[$];
    int          m_next = 0, m_acked = 4095, m_timer = 0, m_rnum = 0, m_rp = 0;
    bit          m_rep = 0, m_ov = 0, m_err = 0, m_rt = 0, m_ready = 0, m_acc = 0;
    bit [FW-1:0] m_od = '0;

    function automatic bit [31:0] crc_bits(input bit [DW-1:0] data, input int n);
        bit [31:0] c = 32'hFFFF_FFFF;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = (c << 1) ^ 32'h04C1_1DB7;
            else c = c << 1;
        end
        return ~c;
    endfunction

    function automatic bit [FW-1:0] mk_frame(input int seq, input bit [TLP_W-1:0] t);
        bit [DW-1:0] h;
        h = {4'b0000, 12'(seq), t};
        return {h, crc_bits(h, DW)};
    endfunction

    function automatic bit [TLP_W-1:0] rand_tlp();
        bit [TLP_W-1:0] t;
        for (int i = 0; i < TLP_W / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_next = 0; m_acked = 4095; m_timer = 0; m_rnum = 0; m_rp = 0;
        m_rep = 0; m_ov = 0; m_err = 0; m_rt = 0; m_od = '0;
    endtask

    task automatic m_update();
        bit loadable, ack, nak, ok, ackprog, trig, loaded, old_rep;
        bit [11:0] dd;
        int cnt, d, purge, left, rp_adj;
        bit [FW-1:0] f;
        loadable = !m_ov || phy_ready_i;
        cnt      = mq.size();
        dd       = dllp_seq_i - 12'(m_acked);
        d        = int'(dd);
        ack      = dllp_valid_i && dllp_type_i == 8'h00;
        nak      = dllp_valid_i && dllp_type_i == 8'h10;
        ok       = (ack || nak) && d <= cnt;
        purge    = ok ? d : 0;
        ackprog  = ok && ack && d > 0;
        old_rep  = m_rep;
        m_acc    = tlp_valid_i && m_ready;
        for (int i = 0; i < purge; i++) void'(mq.pop_front());
        if (ok && d > 0) m_acked = int'(dllp_seq_i);
        left = mq.size();
        trig = (left > 0) && ((ok && nak) || (!old_rep && cnt > 0 && m_timer == RT - 1 && !ackprog));
        m_rt  = trig && m_rnum == 3;
        m_err = (ack || nak) && !ok;
        if (ackprog) m_rnum = 0;
        else if (trig) m_rnum = (m_rnum + 1) % 4;
        loaded = 0;
        f = '0;
        rp_adj = (m_rp >= purge) ? m_rp - purge : 0;
        if (m_acc) begin
            f = mk_frame(m_next, tlp_i);
            mq.push_back(f);
            m_next = (m_next + 1) % 4096;
            loaded = 1;
        end
        if (trig) begin
            m_rep = 1; m_rp = 0;
        end else if (old_rep) begin
            if (left == 0) begin
                m_rep = 0; m_rp = 0;
            end else if (loadable) begin
                f = mq[rp_adj]; loaded = 1; m_rp = rp_adj + 1;
                if (m_rp >= left) begin m_rep = 0; m_rp = 0; end
            end else begin
                m_rp = rp_adj;
            end
        end
        m_timer = (old_rep || cnt == 0 || trig || ackprog) ? 0 : m_timer + 1;
        if (loadable) begin
            m_ov = loaded;
            if (loaded) m_od = f;
        end
    endtask

    // One clock: compare all outputs against the model, advance the model, then return just after the edge
    task automatic step();
        @(negedge clk);
        if (!rst_n) m_reset();
        m_ready = rst_n && !m_rep && mq.size() < RB_DEPTH && (!m_ov || phy_ready_i);
        chk("tlp_ready", tlp_ready_o, m_ready);
        chk("phy_valid", phy_valid_o, m_ov);
        if (m_ov) chk("phy_tlp", phy_tlp_o, m_od);
        chk("replay_active", replay_active_o, m_rep);
        chk("link_retrain", link_retrain_o, m_rt);
        chk("dllp_err", dllp_err_o, m_err);
        chk("rb_count", rb_count_o, mq.size());
        m_acc = 0;
        if (rst_n) m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tlp();
        tlp_valid_i = 1'b1;
        tlp_i = rand_tlp();
        for (int k = 0; k < 300; k++) begin
            step();
            if (m_acc) break;
        end
        if (!m_acc) begin
            checks++; errors++;
            $display("FAIL send_tlp: got no accept expected accept within 300 cycles");
        end
        tlp_valid_i = 1'b0;
    endtask

    task automatic dllp(input bit [7:0] ty, input int seq);
        dllp_valid_i = 1'b1; dllp_type_i = ty; dllp_seq_i = 12'(seq);
        step();
        dllp_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    function automatic int seq_of(input logic [FW-1:0] fr);
        return int'(fr[FW-5 -: 12]);
    endfunction

    initial begin
        int n, rises, rt_cnt, got[$];
        bit prev;
        do_reset();
        chk("reset_count", rb_count_o, 0);
        chk("reset_valid", phy_valid_o, 0);
        chk("crc_check_value", crc_bits(DW'(72'h313233343536373839), 72), 32'hFC89_1918);

        // Three TLPs, then a partial Ack
        for (int i = 0; i < 3; i++) begin
            send_tlp();
            chk("seq_basic", seq_of(phy_tlp_o), i);
        end
        chk("count_three", rb_count_o, 3);
        dllp(8'h00, 1);
        chk("count_after_ack1", rb_count_o, 1);

        // Fill the buffer, backpressure, then full Ack
        do_reset();
        for (int i = 0; i < RB_DEPTH; i++) send_tlp();
        tlp_valid_i = 1'b1;
        step();
        chk("full_ready", tlp_ready_o, 0);
        dllp(8'h00, 7);
        chk("count_after_ack7", rb_count_o, 0);
        chk("ready_after_ack7", tlp_ready_o, 1);
        tlp_valid_i = 1'b0;
        step();

        // Nak purges seq 0 and replays 1..3
        do_reset();
        for (int i = 0; i < 4; i++) send_tlp();
        dllp(8'h10, 0);
        chk("nak_replay_active", replay_active_o, 1);
        chk("nak_count", rb_count_o, 3);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            if (phy_valid_o) got.push_back(seq_of(phy_tlp_o));
        end
        chk("nak_frames", got.size(), 3);
        if (got.size() == 3) begin
            chk("nak_seq_a", got[0], 1);
            chk("nak_seq_b", got[1], 2);
            chk("nak_seq_c", got[2], 3);
        end
        chk("nak_back_normal", replay_active_o, 0);

        // Replay timer expiry and replay_num rollover
        do_reset();
        send_tlp();
        send_tlp();
        n = 1;
        while (n < 1200 && !replay_active_o) begin step(); n++; end
        chk("timeout_cycle", n, 1024);
        rises = 1; rt_cnt = 0;
        for (int k = 0; k < 6000 && rises < 4; k++) begin
            prev = replay_active_o;
            step();
            if (replay_active_o && !prev) rises++;
            if (link_retrain_o) begin
                rt_cnt++;
                chk("retrain_on_4th", rises, 4);
            end
        end
        step();
        chk("trigger_count", rises, 4);
        chk("retrain_pulses", rt_cnt, 1);

        // Sequence wrap 4095 -> 0 and out-of-window Ack
        do_reset();
        for (int i = 0; i < 4094; i++) begin
            send_tlp();
            dllp(8'h00, i);
        end
        for (int i = 0; i < 4; i++) begin
            send_tlp();
            chk("wrap_seq", seq_of(phy_tlp_o), (4094 + i) % 4096);
        end
        dllp(8'h00, 0);
        chk("wrap_ack_count", rb_count_o, 1);
        dllp(8'h00, 100);
        chk("bad_ack_err", dllp_err_o, 1);
        chk("bad_ack_count", rb_count_o, 1);

        // Reset during replay with PHY stalled
        do_reset();
        for (int i = 0; i < 4; i++) send_tlp();
        phy_ready_i = 1'b0;
        dllp(8'h10, 4095);
        chk("stall_replay_active", replay_active_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", phy_valid_o, 0);
        chk("rst_count", rb_count_o, 0);
        chk("rst_replay", replay_active_o, 0);
        chk("rst_ready", tlp_ready_o, 0);
        step(); step();
        rst_n = 1'b1;
        phy_ready_i = 1'b1;
        send_tlp();
        chk("first_seq_after_rst", seq_of(phy_tlp_o), 0);

        // Randomized traffic: frequent DLLPs, then sparse DLLPs so the timer fires
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int k = 0; k < 3500; k++) begin
                tlp_valid_i  = ($urandom % 2) == 0;
                tlp_i        = rand_tlp();
                phy_ready_i  = ($urandom % 4) != 0;
                dllp_valid_i = (phase == 0) ? (($urandom % 10) == 0) : (($urandom % 500) == 0);
                case ($urandom % 5)
                    0, 1:    dllp_type_i = 8'h00;
                    2, 3:    dllp_type_i = 8'h10;
                    default: dllp_type_i = 8'($urandom);
                endcase
                if (($urandom % 8) == 0) dllp_seq_i = 12'($urandom);
                else dllp_seq_i = 12'(m_acked + $urandom_range(0, mq.size() + 2));
                step();
            end
            tlp_valid_i = 1'b0; dllp_valid_i = 1'b0; phy_ready_i = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
